// File: rtl/booth_mul_seq_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

    // RV32M/RV64M multiply flavours as encoded on i_op
    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,   // MUL    : low half, signedness irrelevant
        MUL_HSS = 2'b01,   // MULH   : high half, signed x signed
        MUL_HSU = 2'b10,   // MULHSU : high half, signed x unsigned
        MUL_HUU = 2'b11    // MULHU  : high half, unsigned x unsigned
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } booth_state_t;

    // Radix-4 digits needed for an (xlen+2)-bit operand, rounded up so every
    // cycle retires exactly dpc digits. Extra digits see only sign bits of B
    // and therefore recode to zero.
    function automatic int booth_nd(input int xlen, input int dpc);
        int nd;
        nd = (xlen + 2) / 2;
        if ((nd % dpc) != 0) begin
            nd = nd + dpc - (nd % dpc);
        end
        return nd;
    endfunction

    // Number of CALC cycles for one operation
    function automatic int booth_ncyc(input int xlen, input int dpc);
        return booth_nd(xlen, dpc) / dpc;
    endfunction

endpackage

// File: rtl/booth_mul_seq_pp_digit.sv
// Radix-4 Booth digit cell: recodes a 3-bit window of B into a partial product of A.
// Latency: purely combinational.
// Backpressure: none; driven every cycle by the owning datapath.
module booth_pp_digit #(
    parameter int W = 34
) (
    input  logic [2:0] i_win,
    input  logic [W-1:0] i_a,
    output logic [W:0] o_pp,
    output logic o_neg
);

    logic [W:0] w_a1;
    logic [W:0] w_a2;
    logic [W:0] w_mag;
    logic       w_neg;

    // A and 2A both sign-extended to W+1 bits so 2A cannot overflow
    assign w_a1 = {i_a[W-1], i_a};
    assign w_a2 = {i_a, 1'b0};

    // Window recoding: magnitude select and sign. Negative digits are
    // emitted as ~mag with o_neg supplying the +1 of the two's complement.
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (i_win)
            3'b001, 3'b010: w_mag = w_a1;
            3'b011:         w_mag = w_a2;
            3'b100: begin
                w_mag = w_a2;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = w_a1;
                w_neg = 1'b1;
            end
            default: begin
                w_mag = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    assign o_pp  = w_neg ? ~w_mag : w_mag;
    assign o_neg = w_neg;

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU), DIGITS_PER_CYCLE digits per clock.
// Latency: o_valid NCYC edges after the accept edge (17 for XLEN=32, DPC=1; 9 with DPC=2).
// Backpressure: single operation in flight; o_ready only in IDLE, result held in DONE until i_ready.
// Optional: define BOOTH_MUL_ZERO_BYPASS_EN to finish zero-operand requests on the accept edge.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_data_a,
    input  logic [XLEN-1:0] i_data_b,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    // W: extended operand width (room for the unsigned MSB plus Booth sign)
    // LB: multiplier register width, padded so every digit slot is filled
    localparam int W    = XLEN + 2;
    localparam int ND   = booth_nd(XLEN, DIGITS_PER_CYCLE);
    localparam int NCYC = booth_ncyc(XLEN, DIGITS_PER_CYCLE);
    localparam int LB   = 2 * ND;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    booth_state_t    r_state;
    booth_state_t    w_state_nxt;
    mul_op_t         r_op;
    mul_op_t         w_op_in;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_h;
    logic [LB:0]     r_lx;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [W-1:0]    w_a_ext;
    logic [LB-1:0]   w_b_ext;

    logic [W:0]      w_pp0;
    logic            w_neg0;
    logic [W-1:0]    w_h1;
    logic [LB:0]     w_lx1;
    logic [W-1:0]    w_h_nxt;
    logic [LB:0]     w_lx_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_res;

`ifdef BOOTH_MUL_ZERO_BYPASS_EN
    logic            w_zero_op;
    assign w_zero_op = (i_data_a == '0) || (i_data_b == '0);
`endif

    // One Booth step: add the partial product into the upper accumulator,
    // then arithmetic-shift {acc, B, b[-1]} right by two. The W+2-bit sum
    // absorbs +/-2A; after the shift the running value fits back in W bits.
    function automatic logic [W+LB:0] add_shift(
        input logic [W-1:0]  h,
        input logic [LB-2:0] lx_hi,
        input logic [W:0]    pp,
        input logic          neg
    );
        logic [W+1:0] sum;
        sum = {{2{h[W-1]}}, h} + {pp[W], pp} + {{(W+1){1'b0}}, neg};
        return {sum[W+1:2], sum[1:0], lx_hi};
    endfunction

    assign w_op_in  = mul_op_t'(i_op);
    assign w_accept = (r_state == IDLE) && i_valid && !i_kill;

    // A is signed for MULH/MULHSU, B only for MULH; unsigned operands get
    // zero extension so a single signed datapath covers all four flavours.
    assign w_sign_a = (w_op_in == MUL_HSS) || (w_op_in == MUL_HSU);
    assign w_sign_b = (w_op_in == MUL_HSS);
    assign w_a_ext  = {{2{w_sign_a & i_data_a[XLEN-1]}}, i_data_a};
    assign w_b_ext  = {{(LB-XLEN){w_sign_b & i_data_b[XLEN-1]}}, i_data_b};

    // First digit of the cycle always comes from the registered window
    booth_pp_digit #(.W(W)) u_pp0 (
        .i_win (r_lx[2:0]),
        .i_a   (r_a),
        .o_pp  (w_pp0),
        .o_neg (w_neg0)
    );

    assign {w_h1, w_lx1} = add_shift(r_h, r_lx[LB:2], w_pp0, w_neg0);

    generate
        if (DIGITS_PER_CYCLE == 2) begin : g_dpc2
            logic [W:0] w_pp1;
            logic       w_neg1;

            // Second cell works on the already-shifted intermediate state
            booth_pp_digit #(.W(W)) u_pp1 (
                .i_win (w_lx1[2:0]),
                .i_a   (r_a),
                .o_pp  (w_pp1),
                .o_neg (w_neg1)
            );

            assign {w_h_nxt, w_lx_nxt} = add_shift(w_h1, w_lx1[LB:2], w_pp1, w_neg1);
        end else begin : g_dpc1
            assign w_h_nxt  = w_h1;
            assign w_lx_nxt = w_lx1;
        end
    endgenerate

    // After the final step {acc, B} holds the full product; bit 0 of the
    // B register is the Booth look-behind bit and is not part of it.
    assign w_prod = (2*XLEN)'({w_h_nxt, w_lx_nxt[LB:1]});
    assign w_res  = (r_op == MUL_LO) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill overrides everything including a same-cycle accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
                    w_state_nxt = w_zero_op ? DONE : CALC;
`else
                    w_state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_kill) begin
            w_state_nxt = IDLE;
        end
    end

    // Datapath: load operands on accept, iterate in CALC, capture result on the last step
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= MUL_LO;
            r_a      <= '0;
            r_h      <= '0;
            r_lx     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= w_op_in;
            r_a   <= w_a_ext;
            r_h   <= '0;
            r_lx  <= {w_b_ext, 1'b0};
            r_cnt <= CW'(NCYC - 1);
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
            if (w_zero_op) begin
                r_result <= '0;
            end
`endif
        end else if ((r_state == CALC) && !i_kill) begin
            r_h   <= w_h_nxt;
            r_lx  <= w_lx_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_result <= w_res;
            end
        end
    end

    assign o_ready  = (r_state == IDLE);
    assign o_valid  = (r_state == DONE);
    assign o_busy   = (r_state != IDLE);
    assign o_result = r_result;

endmodule
